// File: rtl/cmul_rr_scheduler.sv
// Round-robin scheduler sharing one complex_mul IP core between NREQ requesters.
// Optional sticky protocol-error flag enabled by defining CMUL_SCHED_ERR_CHECK_EN.
module cmul_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int SIZE  = 16,
    parameter int DEPTH = 8,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*SIZE-1:0]   req_a,
    input  logic [NREQ*SIZE-1:0]   req_b,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   drain,
    output logic                   idle,
    output logic                   mul_a_tvalid,
    output logic [SIZE-1:0]        mul_a_tdata,
    output logic                   mul_b_tvalid,
    output logic [SIZE-1:0]        mul_b_tdata,
    input  logic                   mul_dout_tvalid,
    input  logic [3*SIZE-1:0]      mul_dout_tdata,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [3*SIZE-1:0]      rsp_data,
    output logic                   err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [IDW-1:0]    r_ptr;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [IDW-1:0]    r_tags [DEPTH];
    logic              r_mul_valid;
    logic [SIZE-1:0]   r_mul_a;
    logic [SIZE-1:0]   r_mul_b;
    logic              r_rsp_valid;
    logic [IDW-1:0]    r_rsp_id;
    logic [3*SIZE-1:0] r_rsp_data;

    logic              w_gnt_found;
    logic [IDW-1:0]    w_winner;
    logic [IDW-1:0]    w_idx;
    logic              w_can_issue;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_gnt_found = 1'b0;
        w_winner    = '0;
        w_idx       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = IDW'((int'(r_ptr) + i) % NREQ);
            if (!w_gnt_found && req_valid[w_idx]) begin
                w_gnt_found = 1'b1;
                w_winner    = w_idx;
            end
        end
    end

    // A full FIFO blocks issue even when a pop lands in the same cycle.
    assign w_can_issue = (r_state == StRun) && !drain && (r_count != CW'(DEPTH));
    assign w_push      = w_can_issue && w_gnt_found;
    assign w_pop       = mul_dout_tvalid && (r_count != '0);

    always_comb begin
        req_ready = '0;
        if (w_push) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (!drain) w_state_nxt = StRun;
            StRun:   if (drain) w_state_nxt = StDrain;
            StDrain: if ((r_count == '0) && !w_pop) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_count <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_ptr <= w_winner;
                r_wr  <= f_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= f_inc(r_rd);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Tag storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tags[r_wr] <= w_winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_valid <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            r_mul_valid <= w_push;
            if (w_push) begin
                r_mul_a <= req_a[int'(w_winner) * SIZE +: SIZE];
                r_mul_b <= req_b[int'(w_winner) * SIZE +: SIZE];
            end
        end
    end

    // Results arriving with no tag outstanding are stale and silently dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_pop;
            if (w_pop) begin
                r_rsp_id   <= r_tags[r_rd];
                r_rsp_data <= mul_dout_tdata;
            end
        end
    end

`ifdef CMUL_SCHED_ERR_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((mul_dout_tvalid && (r_count == '0)) ||
                     (w_push && (r_count == CW'(DEPTH)))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign idle         = (r_state == StIdle);
    assign mul_a_tvalid = r_mul_valid;
    assign mul_b_tvalid = r_mul_valid;
    assign mul_a_tdata  = r_mul_a;
    assign mul_b_tdata  = r_mul_b;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_data     = r_rsp_data;

endmodule

// File: tb/tb_cmul_rr_scheduler.sv
// Scoreboard bench for cmul_rr_scheduler; the IP is modelled as a 4-stage adder pipeline.
module tb_cmul_rr_scheduler;

    localparam int NREQ   = 4;
    localparam int SIZE   = 16;
    localparam int IDW    = 2;
    localparam int LAT    = 4;
    localparam int RSPLAT = LAT + 2;

    typedef struct packed {
        logic [IDW-1:0]    id;
        logic [3*SIZE-1:0] data;
        int                cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*SIZE-1:0] req_a, req_b;
    logic                 drain = 1'b0;
    logic                 use4 = 1'b0;

    logic [NREQ-1:0] rv8, rr8, rv4, rr4;
    logic idle8, ma_v8, mb_v8, dv8, rsp_v8, err8;
    logic idle4, ma_v4, mb_v4, dv4, rsp_v4, err4;
    logic [SIZE-1:0] ma_d8, mb_d8, ma_d4, mb_d4;
    logic [3*SIZE-1:0] dd8, rsp_d8, dd4, rsp_d4;
    logic [IDW-1:0] rsp_id8, rsp_id4;

    assign rv8 = use4 ? '0 : req_valid;
    assign rv4 = use4 ? req_valid : '0;

    cmul_rr_scheduler #(.NREQ(NREQ), .SIZE(SIZE), .DEPTH(8), .IDW(IDW)) dut8 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv8), .req_a(req_a), .req_b(req_b),
        .req_ready(rr8), .drain(drain), .idle(idle8),
        .mul_a_tvalid(ma_v8), .mul_a_tdata(ma_d8), .mul_b_tvalid(mb_v8), .mul_b_tdata(mb_d8),
        .mul_dout_tvalid(dv8), .mul_dout_tdata(dd8),
        .rsp_valid(rsp_v8), .rsp_id(rsp_id8), .rsp_data(rsp_d8), .err(err8)
    );

    cmul_rr_scheduler #(.NREQ(NREQ), .SIZE(SIZE), .DEPTH(4), .IDW(IDW)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv4), .req_a(req_a), .req_b(req_b),
        .req_ready(rr4), .drain(drain), .idle(idle4),
        .mul_a_tvalid(ma_v4), .mul_a_tdata(ma_d4), .mul_b_tvalid(mb_v4), .mul_b_tdata(mb_d4),
        .mul_dout_tvalid(dv4), .mul_dout_tdata(dd4),
        .rsp_valid(rsp_v4), .rsp_id(rsp_id4), .rsp_data(rsp_d4), .err(err4)
    );

    // IP models: not reset, so results in flight survive a scheduler reset.
    logic [LAT-1:0]    p8_v = '0, p4_v = '0;
    logic [3*SIZE-1:0] p8_d [LAT];
    logic [3*SIZE-1:0] p4_d [LAT];
    always @(posedge clk) begin
        p8_v    <= {p8_v[LAT-2:0], ma_v8};
        p4_v    <= {p4_v[LAT-2:0], ma_v4};
        p8_d[0] <= (3*SIZE)'(ma_d8) + (3*SIZE)'(mb_d8);
        p4_d[0] <= (3*SIZE)'(ma_d4) + (3*SIZE)'(mb_d4);
        for (int k = 1; k < LAT; k++) begin
            p8_d[k] <= p8_d[k-1];
            p4_d[k] <= p4_d[k-1];
        end
    end
    assign dv8 = p8_v[LAT-1];
    assign dd8 = p8_d[LAT-1];
    assign dv4 = p4_v[LAT-1];
    assign dd4 = p4_d[LAT-1];

    logic [NREQ-1:0]   m_rr, m_rv;
    logic              m_idle, m_ma_v, m_mb_v, m_rsp_v, m_err, m_dv;
    logic [SIZE-1:0]   m_ma_d, m_mb_d;
    logic [IDW-1:0]    m_rsp_id;
    logic [3*SIZE-1:0] m_rsp_d;
    assign m_rr     = use4 ? rr4 : rr8;
    assign m_rv     = use4 ? rv4 : rv8;
    assign m_idle   = use4 ? idle4 : idle8;
    assign m_ma_v   = use4 ? ma_v4 : ma_v8;
    assign m_mb_v   = use4 ? mb_v4 : mb_v8;
    assign m_ma_d   = use4 ? ma_d4 : ma_d8;
    assign m_mb_d   = use4 ? mb_d4 : mb_d8;
    assign m_rsp_v  = use4 ? rsp_v4 : rsp_v8;
    assign m_rsp_id = use4 ? rsp_id4 : rsp_id8;
    assign m_rsp_d  = use4 ? rsp_d4 : rsp_d8;
    assign m_err    = use4 ? err4 : err8;
    assign m_dv     = use4 ? dv4 : dv8;

    logic [SIZE-1:0]   op_a [NREQ] = '{16'h1234, 16'h00ff, 16'h0101, 16'hffff};
    logic [SIZE-1:0]   op_b [NREQ] = '{16'h0001, 16'h0001, 16'h0202, 16'hffff};
    logic [3*SIZE-1:0] exp_sum [NREQ] = '{48'h1235, 48'h100, 48'h303, 48'h1fffe};

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [IDW-1:0] exp_gnt_q [$];
    rsp_t           exp_rsp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Grant monitor: compares against the directed grant order, queues the response.
    logic [IDW-1:0] g_id;
    always @(negedge clk) begin
        if (rst_n && (m_rr != '0)) begin
            if (exp_gnt_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_grant: got req_ready=%b required none", m_rr);
            end else begin
                g_id = exp_gnt_q.pop_front();
                check("grant", 64'(m_rr), 64'(1) << g_id);
                exp_rsp_q.push_back('{id: g_id, data: exp_sum[g_id], cyc: cyc + RSPLAT});
            end
        end
    end

    rsp_t r_exp;
    int   rsp_seen = 0;
    always @(negedge clk) begin
        if (rst_n && m_rsp_v) begin
            rsp_seen++;
            if (exp_rsp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got id=%0d data=%0h required none", m_rsp_id,
                         m_rsp_d);
            end else begin
                r_exp = exp_rsp_q.pop_front();
                check("rsp_id", 64'(m_rsp_id), 64'(r_exp.id));
                check("rsp_data", 64'(m_rsp_d), 64'(r_exp.data));
                check("rsp_latency", 64'(cyc), 64'(r_exp.cyc));
            end
        end
    end

    int  dv_seen = 0;
    bit  track = 1'b0;
    int  peak = 0;
    always @(negedge clk) begin
        if (m_dv) dv_seen++;
        if (track && (int'(dut8.r_count) > peak)) peak = int'(dut8.r_count);
    end

    task automatic do_reset();
        req_valid = '0;
        drain     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_gnt_q.delete();
        exp_rsp_q.delete();
        check("reset_outputs",
              64'({m_rr, m_ma_v, m_mb_v, m_ma_d, m_mb_d, m_rsp_v, m_rsp_id, m_err, m_idle}),
              64'({4'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b1}));
        check("reset_rsp_data", 64'(m_rsp_d), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_grants(input int n, output int first_c, output int last_c);
        int got = 0;
        int budget = 0;
        first_c = -1;
        last_c  = -1;
        while (got < n && budget < 100) begin
            @(negedge clk);
            budget++;
            if ((m_rr & m_rv) != '0) begin
                got++;
                if (got == 1) first_c = cyc;
                last_c = cyc;
            end
        end
        check("grant_count", 64'(got), 64'(n));
    endtask

    task automatic wait_drained();
        int budget = 0;
        while ((exp_rsp_q.size() != 0 || exp_gnt_q.size() != 0) && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        check("drained", 64'(exp_rsp_q.size() + exp_gnt_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    int f, l, f2, l2;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*SIZE +: SIZE] = op_a[i];
            req_b[i*SIZE +: SIZE] = op_b[i];
        end

        // 1: single op from requester 2
        do_reset();
        exp_gnt_q.push_back(2'd2);
        @(posedge clk); #1; req_valid = 4'b0100;
        wait_grants(1, f, l);
        @(posedge clk); #1; req_valid = '0;
        check("t1_issue", 64'({m_ma_v, m_mb_v, m_ma_d, m_mb_d}),
              64'({1'b1, 1'b1, 16'h0101, 16'h0202}));
        @(posedge clk); #1;
        check("t1_pulse_width", 64'({m_ma_v, m_mb_v}), 64'd0);
        wait_drained();

        // 2: all four requesters, eight grants
        do_reset();
        for (int r = 0; r < 2; r++) begin
            exp_gnt_q.push_back(2'd1); exp_gnt_q.push_back(2'd2);
            exp_gnt_q.push_back(2'd3); exp_gnt_q.push_back(2'd0);
        end
        @(posedge clk); #1; req_valid = 4'b1111;
        wait_grants(8, f, l);
        @(posedge clk); #1; req_valid = '0;
        check("t2_back_to_back", 64'(l - f), 64'd7);
        wait_drained();

        // 3: DEPTH=4 instance fills and then tracks pops
        use4 = 1'b1;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            exp_gnt_q.push_back(2'd1); exp_gnt_q.push_back(2'd2);
            exp_gnt_q.push_back(2'd3); exp_gnt_q.push_back(2'd0);
        end
        @(posedge clk); #1; req_valid = 4'b1111;
        wait_grants(4, f, l);
        @(negedge clk);
        check("t3_full_stall_a", 64'(m_rr), 64'd0);
        @(negedge clk);
        check("t3_full_stall_b", 64'(m_rr), 64'd0);
        wait_grants(8, f2, l2);
        @(posedge clk); #1; req_valid = '0;
        check("t3_resume_cycle", 64'(f2 - l), 64'd3);
        wait_drained();
        use4 = 1'b0;

        // 4: drain while streaming
        do_reset();
        exp_gnt_q.push_back(2'd1); exp_gnt_q.push_back(2'd2); exp_gnt_q.push_back(2'd3);
        @(posedge clk); #1; req_valid = 4'b1111;
        wait_grants(3, f, l);
        @(posedge clk); #1; drain = 1'b1;
        @(negedge clk);
        check("t4_no_grant_on_drain", 64'(m_rr), 64'd0);
        while (cyc < l + RSPLAT) @(negedge clk);
        check("t4_last_rsp", 64'({m_rsp_v, m_idle}), 64'({1'b1, 1'b0}));
        @(negedge clk);
        check("t4_idle", 64'(m_idle), 64'd1);
        check("t4_all_delivered", 64'(exp_rsp_q.size()), 64'd0);
        @(posedge clk); #1; drain = 1'b0;
        exp_gnt_q.push_back(2'd0);
        wait_grants(1, f, l);
        @(posedge clk); #1; req_valid = '0;
        wait_drained();

        // 5: reset with three ops in the IP pipeline
        do_reset();
        exp_gnt_q.push_back(2'd1); exp_gnt_q.push_back(2'd1); exp_gnt_q.push_back(2'd1);
        @(posedge clk); #1; req_valid = 4'b0010;
        wait_grants(3, f, l);
        @(posedge clk); #1; req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_rsp_q.delete();
        check("t5_async_reset", 64'({m_ma_d, m_ma_v, m_rsp_v, m_idle, m_rr}),
              64'({16'h0, 1'b0, 1'b0, 1'b1, 4'b0}));
        rsp_seen = 0;
        dv_seen  = 0;
        @(negedge clk); #1; rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_late_results", 64'(dv_seen), 64'd3);
        check("t5_no_rsp", 64'(rsp_seen), 64'd0);
`ifdef CMUL_SCHED_ERR_CHECK_EN
        check("t5_err", 64'(m_err), 64'd1);
`else
        check("t5_err", 64'(m_err), 64'd0);
`endif

        // 6: lone requester 0 is never starved
        do_reset();
        for (int r = 0; r < 8; r++) exp_gnt_q.push_back(2'd0);
        peak  = 0;
        track = 1'b1;
        @(posedge clk); #1; req_valid = 4'b0001;
        wait_grants(8, f, l);
        @(posedge clk); #1; req_valid = '0;
        check("t6_back_to_back", 64'(l - f), 64'd7);
        wait_drained();
        track = 1'b0;
        check("t6_count_peak", 64'(peak), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
